instr_loader: RTL

Program loader that writes into the instruction memory from a byte stream in the program-file text format. It is the write side of the text format the instruction memory fetch path reads. Each line holds 32 ASCII binary digits, MSB first, and ends with a newline. The block parses the stream, assembles 32-bit words and issues word writes at consecutive byte addresses (step 4) to a synthesizable instruction RAM. It sits between the test/boot stream source and the instruction RAM write port, and reports completion, errors and the number of instructions loaded.

---
 rtl/instr_loader.sv | 99 +++++++++
 1 files changed

// File: rtl/instr_loader.sv
// instr_loader: parses an ASCII binary program stream into 32-bit words and writes them to instruction RAM
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               one-cycle pulse that begins a load (ignored while busy)
//   in_valid/in_ready   byte stream handshake; in_data is the ASCII byte, in_last flags the final byte
//   mem_we/mem_ready    RAM write handshake; mem_addr/mem_wdata held until mem_ready is seen
//   busy                load in progress
//   done, error         sticky completion / abort flags, cleared by start
//   word_count          number of words written in the current load
module instr_loader #(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int                 MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE, S_ERROR} state_t;
  state_t      state, nxt;
  logic [31:0] shreg;
  logic [5:0]  cnt, cnt_after;
  logic        last;
  logic        accept, digit, nl, cr, bad, full, wr, fin, err_last, cap, idle_like;

  assign idle_like = state == S_IDLE || state == S_DONE || state == S_ERROR;
  assign accept    = in_valid && state == S_LOAD;
  assign digit     = in_data == 8'h30 || in_data == 8'h31;
  assign nl        = in_data == 8'h0A;
  assign cr        = in_data == 8'h0D;
  assign cnt_after = cnt + {5'd0, digit};
  assign full      = cnt_after == 6'd32;
  // A byte is malformed on its own, before in_last is considered
  assign bad       = !(digit || nl || cr) || (digit && cnt == 6'd32) || (nl && cnt != 6'd0 && cnt != 6'd32);
  // A complete word is written on its newline, or on in_last when no newline follows
  assign wr        = !bad && full && (nl || in_last);
  assign fin       = !bad && in_last && cnt_after == 6'd0;
  assign err_last  = !bad && in_last && !full && cnt_after != 6'd0;
  assign cap       = word_count == 16'(MAX_WORDS);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: nxt = start ? S_LOAD : state;
      S_LOAD: if (accept) nxt = (bad || err_last) ? S_ERROR : wr ? (cap ? S_ERROR : S_WRITE) : fin ? S_DONE : S_LOAD;
      S_WRITE: if (mem_ready) nxt = last ? S_DONE : S_LOAD;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = state == S_LOAD;
    mem_we    = state == S_WRITE;
    busy      = state == S_LOAD || state == S_WRITE;
    done      = state == S_DONE;
    error     = state == S_ERROR;
    mem_wdata = shreg;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shreg      <= '0;
      cnt        <= '0;
      word_count <= '0;
      mem_addr   <= BASE_ADDR;
      last       <= 1'b0;
    end else if (start && idle_like) begin
      shreg      <= '0;
      cnt        <= '0;
      word_count <= '0;
      mem_addr   <= BASE_ADDR;
      last       <= 1'b0;
    end else if (accept) begin
      if (digit) shreg <= {shreg[30:0], in_data[0]};
      cnt  <= cnt_after;
      last <= in_last;
    end else if (state == S_WRITE && mem_ready) begin
      mem_addr   <= mem_addr + ADDR_W'(4);
      word_count <= word_count + 16'd1;
      cnt        <= '0;
    end
endmodule
